// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state type and opcode classification helpers
// for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_SRA;
    endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle arithmetic/logic datapath (ADD..XOR) with status flags.
// Shift opcodes and unsupported codes yield zero here; the top handles them.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             sign,
    output logic             zero
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit of the difference is the unsigned borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = diff[WIDTH-1:0];
                carry    = diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  result = ~a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

    assign sign = result[WIDTH-1];
    assign zero = (result == '0);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: handshaked single-operation pipeline with a one-bit-per-cycle
// iterative shifter; result and flags are registered and held until consumed.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             sign_flag,
    output logic             overflow_flag,
    output logic             zero_flag,
    output logic             illegal_op
);

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [3:0]         op_reg;
    logic [WIDTH-1:0]   sh_reg;
    logic [SHAMT_W-1:0] cnt_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               carry_reg;
    logic               sign_reg;
    logic               overflow_reg;
    logic               zero_reg;
    logic               illegal_reg;
    logic               out_valid_reg;

    logic [WIDTH-1:0]   comb_result;
    logic               comb_carry;
    logic               comb_overflow;
    logic               comb_sign;
    logic               comb_zero;
    logic [WIDTH-1:0]   sh_next;
    logic               sh_out;
    logic [SHAMT_W-1:0] shamt;

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .a        (a_reg),
        .b        (b_reg),
        .op       (op_reg),
        .result   (comb_result),
        .carry    (comb_carry),
        .overflow (comb_overflow),
        .sign     (comb_sign),
        .zero     (comb_zero)
    );

    assign shamt = b_reg[SHAMT_W-1:0];

    // One-position shift step; SRA re-copies the MSB, which stays the original A MSB.
    always_comb begin
        sh_next = sh_reg;
        sh_out  = 1'b0;
        case (op_reg)
            OP_SLL: begin
                sh_next = {sh_reg[WIDTH-2:0], 1'b0};
                sh_out  = sh_reg[WIDTH-1];
            end
            OP_SRL: begin
                sh_next = {1'b0, sh_reg[WIDTH-1:1]};
                sh_out  = sh_reg[0];
            end
            OP_SRA: begin
                sh_next = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
                sh_out  = sh_reg[0];
            end
            default: begin
                sh_next = sh_reg;
                sh_out  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            sh_reg        <= '0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            sign_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        op_reg    <= op_code;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (!is_legal(op_reg)) begin
                        result_reg    <= '0;
                        carry_reg     <= 1'b0;
                        sign_reg      <= 1'b0;
                        overflow_reg  <= 1'b0;
                        zero_reg      <= 1'b0;
                        illegal_reg   <= 1'b1;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else if (is_shift(op_reg) && (shamt != '0)) begin
                        sh_reg    <= a_reg;
                        cnt_reg   <= shamt;
                        state_reg <= SHIFT;
                    end else if (is_shift(op_reg)) begin
                        result_reg    <= a_reg;
                        carry_reg     <= 1'b0;
                        sign_reg      <= a_reg[WIDTH-1];
                        overflow_reg  <= 1'b0;
                        zero_reg      <= (a_reg == '0);
                        illegal_reg   <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        result_reg    <= comb_result;
                        carry_reg     <= comb_carry;
                        sign_reg      <= comb_sign;
                        overflow_reg  <= comb_overflow;
                        zero_reg      <= comb_zero;
                        illegal_reg   <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                SHIFT: begin
                    sh_reg  <= sh_next;
                    cnt_reg <= cnt_reg - SHAMT_W'(1);
                    if (cnt_reg == SHAMT_W'(1)) begin
                        result_reg    <= sh_next;
                        carry_reg     <= sh_out;
                        sign_reg      <= sh_next[WIDTH-1];
                        overflow_reg  <= 1'b0;
                        zero_reg      <= (sh_next == '0);
                        illegal_reg   <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state_reg == IDLE);
    assign out_valid     = out_valid_reg;
    assign result        = result_reg;
    assign carry_flag    = carry_reg;
    assign sign_flag     = sign_reg;
    assign overflow_flag = overflow_reg;
    assign zero_flag     = zero_reg;
    assign illegal_op    = illegal_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed corner cases, reset
// abort during a shift, busy-time back-pressure and randomized operations.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [3:0]  op_code = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        carry_flag, sign_flag, overflow_flag, zero_flag, illegal_op;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_code       (op_code),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .carry_flag    (carry_flag),
        .sign_flag     (sign_flag),
        .overflow_flag (overflow_flag),
        .zero_flag     (zero_flag),
        .illegal_op    (illegal_op)
    );

    // Reference: {result, C, N, V, Z, illegal} from plain arithmetic.
    function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        logic [31:0] r;
        logic signed [31:0] sa;
        logic c, v, ill;
        int s;
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        s = int'(b[4:0]);
        sa = a;
        case (op)
            4'd0: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                r = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2: r = ~a;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: begin r = a << s;  c = (s > 0) ? a[32-s] : 1'b0; end
            4'd7: begin r = a >> s;  c = (s > 0) ? a[s-1]  : 1'b0; end
            4'd8: begin r = sa >>> s; c = (s > 0) ? a[s-1] : 1'b0; end
            default: ill = 1'b1;
        endcase
        if (ill) return {32'd0, 5'b00001};
        return {r, c, r[31], v, (r == 32'd0), 1'b0};
    endfunction

    function automatic int model_latency(input logic [31:0] b, input logic [3:0] op);
        if (op >= 4'd6 && op <= 4'd8) return 2 + int'(b[4:0]);
        return 2;
    endfunction

    // One transaction: entered and left at a negedge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input int hold);
        logic [36:0] exp;
        logic [36:0] got;
        int lat;
        int waited;
        exp = model(a, b, op);
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks_total++;
        if (in_ready !== 1'b1) $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
        else checks_passed++;
        in_valid = 1'b1; op_a = a; op_b = b; op_code = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_code = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        checks_total++;
        if (lat !== model_latency(b, op)) $display("FAIL latency op=%0d: got %0d required %0d", op, lat, model_latency(b, op));
        else checks_passed++;
        got = {result, carry_flag, sign_flag, overflow_flag, zero_flag, illegal_op};
        checks_total++;
        if (got !== exp) $display("FAIL result op=%0d a=%h b=%h: got %h/%b required %h/%b", op, a, b, got[36:5], got[4:0], exp[36:5], exp[4:0]);
        else checks_passed++;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks_total++;
            if ({out_valid, in_ready, result, carry_flag, sign_flag, overflow_flag, zero_flag, illegal_op} !== {2'b10, exp})
                $display("FAIL hold op=%0d cycle %0d: valid=%b ready=%b result=%h required valid=1 ready=0 result=%h", op, i, out_valid, in_ready, result, exp[36:5]);
            else checks_passed++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL handshake op=%0d: valid=%b ready=%b required valid=0 ready=1", op, out_valid, in_ready);
        else checks_passed++;
        $display("op=%0d a=%h b=%h -> result=%h CNVZ=%b%b%b%b ill=%b lat=%0d hold=%0d", op, a, b, exp[36:5], exp[4], exp[3], exp[2], exp[1], exp[0], lat, hold);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks_total++;
        if ({in_ready, out_valid, result, carry_flag, sign_flag, overflow_flag, zero_flag, illegal_op} !== {2'b10, 37'd0})
            $display("FAIL reset_state: ready=%b valid=%b result=%h ill=%b required ready=1 valid=0 result=0 ill=0", in_ready, out_valid, result, illegal_op);
        else checks_passed++;
        rst = 1'b0;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_directed();
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'd0, 0);
        run_op(32'd5, 32'd5, 4'd1, 0);
        run_op(32'd3, 32'd5, 4'd1, 1);
        run_op(32'h8000_0000, 32'd4, 4'd8, 0);
        run_op(32'h8000_0001, 32'd1, 4'd6, 0);
        run_op(32'hFF00_FF00, 32'h0F0F_0F0F, 4'd3, 3);
        run_op(32'h1234_5678, 32'd0, 4'd7, 0);
        run_op(32'h0000_00F0, 32'hFFFF_FFE0, 4'd6, 0);
    endtask

    task automatic test_illegal();
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 4'b1111, 1);
        run_op(32'hDEAD_BEEF, 32'h0000_0001, 4'd9, 0);
        run_op(32'h0000_0010, 32'h0000_0020, 4'd0, 0);
    endtask

    task automatic test_reset_mid_shift();
        logic saw_valid;
        in_valid = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'd31; op_code = 4'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks_total++;
        if ({in_ready, out_valid, result, carry_flag, sign_flag, overflow_flag, zero_flag, illegal_op} !== {2'b10, 37'd0})
            $display("FAIL reset_abort: ready=%b valid=%b result=%h flags=%b%b%b%b ill=%b required ready=1 valid=0 all 0", in_ready, out_valid, result, carry_flag, sign_flag, overflow_flag, zero_flag, illegal_op);
        else checks_passed++;
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        checks_total++;
        if (saw_valid !== 1'b0) $display("FAIL reset_no_valid: out_valid asserted=%b required 0", saw_valid);
        else checks_passed++;
        $display("SRL by 31 aborted by reset");
    endtask

    task automatic test_back_to_back();
        int waited;
        in_valid = 1'b1; op_a = 32'd1; op_b = 32'd2; op_code = 4'd0;
        @(posedge clk);
        #1;
        op_a = 32'd100; op_b = 32'd7; op_code = 4'd1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 100);
        repeat (3) begin
            @(negedge clk);
            checks_total++;
            if ({out_valid, in_ready, result} !== {2'b10, 32'd3})
                $display("FAIL busy_block: valid=%b ready=%b result=%h required valid=1 ready=0 result=00000003", out_valid, in_ready, result);
            else checks_passed++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        $display("ADD 1+2 held while in_valid asserted, result=%h", result);
        run_op(32'd100, 32'd7, 4'd1, 0);
        run_op(32'hA5A5_A5A5, 32'd0, 4'd2, 0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [3:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op(a, b, op, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values 8..64, power of two.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), shift-amount width (derived, not overridden).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 op_a  input  WIDTH  operand A.
REQ-008 op_b  input  WIDTH  operand B; low SHAMT_W bits are shift amount for shift ops.
REQ-009 op_code  input  4  operation select.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 carry_flag, sign_flag, overflow_flag, zero_flag  output  1 each  status flags.
REQ-014 illegal_op  output  1  op_code not in the supported set.

Function
REQ-015 Opcodes: 0 ADD, 1 SUB, 2 NOT(A), 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA; 9..15 illegal.
REQ-016 FSM states IDLE, EXEC, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-017 Accept = in_valid & in_ready; op_a, op_b, op_code captured into internal registers on accept; IDLE -> EXEC.
REQ-018 EXEC (one cycle): non-shift ops and shifts with shamt=0 compute result/flags -> DONE; shifts with shamt>0 -> SHIFT.
REQ-019 SHIFT: one bit position per cycle, shamt cycles total, then -> DONE; shamt counter decrements to 0.
REQ-020 Latency accept-to-out_valid: 2 cycles for non-shift ops, 2+shamt cycles for shifts.
REQ-021 DONE: out_valid=1; result and flags held stable until out_valid & out_ready; then -> IDLE same edge.
REQ-022 No new operation accepted until the current result is consumed (one operation in flight).
REQ-023 ADD: {carry,result}=A+B; overflow = signs of A,B equal and differ from result sign.
REQ-024 SUB: result=A-B; carry = borrow (1 iff A<B unsigned); overflow = A,B signs differ and result sign differs from A.
REQ-025 Logic ops and NOT: carry=0, overflow=0.
REQ-026 SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates original A MSB.
REQ-027 Shifts: carry = last bit shifted out (0 when shamt=0); overflow=0.
REQ-028 All ops: zero_flag = (result==0); sign_flag = result[WIDTH-1].
REQ-029 Illegal op: result=0, all four flags 0, illegal_op=1, 2-cycle latency; illegal_op=0 for legal ops.
REQ-030 result, flags and illegal_op change only on the edge entering DONE; outside DONE they hold last values.

Reset
REQ-031 rst=1 at any edge forces IDLE, in_ready=1 from next cycle, out_valid=0, result=0, all flags=0, illegal_op=0, shift counter=0.
REQ-032 Reset mid-EXEC/SHIFT/DONE aborts the operation; no out_valid is issued for it.
REQ-033 rst takes priority over in_valid and out_ready on the same edge.

Structure
REQ-034 Package alu_seq_pkg holds opcode constants and the FSM state typedef.
REQ-035 Sub-module alu_seq_comb: combinational non-shift datapath (ADD..XOR) producing result and flags, parameterised by WIDTH.
REQ-036 Iterative shifter, shamt counter and FSM reside in alu_seq top.

Verification (WIDTH=32)
REQ-037 ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, V=1, N=1, C=0, Z=0, out_valid 2 cycles after accept.
REQ-038 SUB 5-5 -> 0, Z=1, C=0; SUB 3-5 -> 0xFFFFFFFE, C=1, N=1, V=0.
REQ-039 SRA 0x80000000 by 4 -> 0xF8000000, C=0, out_valid 6 cycles after accept; SLL 0x80000001 by 1 -> 0x00000002, C=1.
REQ-040 AND 0xFF00FF00,0x0F0F0F0F with out_ready low 3 cycles -> 0x0F000F00 held stable, in_ready=0, IDLE after handshake.
REQ-041 SRL by 31 with rst pulsed during SHIFT -> out_valid never asserts, in_ready=1 and all outputs 0 the cycle after rst.
REQ-042 op_code 4'b1111 -> illegal_op=1, result 0, flags 0; following legal ADD clears illegal_op.
